// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encoding and default reset PC.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StStall = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_incr.sv
// PC incrementer: next sequential word address, wrapping modulo 2^Width.
module fetch_sequencer_incr #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] pcin_i,
  output logic [Width-1:0] pcout_o
);

  assign pcout_o = pcin_i + Width'(1);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage PC sequencer with req/ack instruction-memory handshake, stall hold and redirect.
// Optional performance counters (fetch_cnt_o, stall_cnt_o) are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned       Width   = 32,
  parameter logic [Width-1:0] ResetPc = Width'(DefaultResetPc)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      stall_cnt_o,
`endif
  input  logic             stall_i,
  input  logic             pcsrc_i,
  input  logic [Width-1:0] target_i,
  output logic             imem_req_o,
  output logic [Width-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [Width-1:0] imem_data_i,
  output logic             if_valid_o,
  output logic [Width-1:0] if_instr_o,
  output logic [Width-1:0] if_pc_o,
  output logic [Width-1:0] if_npc_o
);

  fetch_state_e     state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [Width-1:0] instr_q, instr_d;
  logic [Width-1:0] ipc_q, ipc_d;
  logic [Width-1:0] inpc_q, inpc_d;
  logic [Width-1:0] pc_inc;
  logic             accept;

  fetch_sequencer_incr #(
    .Width (Width)
  ) u_incr (
    .pcin_i  (pc_q),
    .pcout_o (pc_inc)
  );

  // Request is withdrawn while a held instruction is still waiting on IF/ID.
  assign imem_req_o  = (state_q == StFetch) && !(valid_q && stall_i);
  assign imem_addr_o = pc_q;
  assign accept      = imem_req_o && imem_ack_i && !pcsrc_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    inpc_d  = inpc_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (pcsrc_i) begin
          pc_d    = target_i;
          valid_d = 1'b0;
        end else if (accept) begin
          instr_d = imem_data_i;
          ipc_d   = pc_q;
          inpc_d  = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = stall_i ? StStall : StFetch;
        end else if (valid_q && stall_i) begin
          state_d = StStall;
        end else if (valid_q) begin
          valid_d = 1'b0;
        end
      end
      StStall: begin
        if (pcsrc_i) begin
          pc_d    = target_i;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      inpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      inpc_q  <= inpc_d;
    end
  end

  assign if_valid_o = valid_q;
  assign if_instr_o = instr_q;
  assign if_pc_o    = ipc_q;
  assign if_npc_o   = inpc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if ((state_q == StStall) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, corner sequences, random vs model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, pcsrc, ack;
  logic [31:0] target, data;
  logic        req, valid;
  logic [31:0] addr, instr, ipc, inpc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .Width   (32),
    .ResetPc (32'h0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o (fetch_cnt),
    .stall_cnt_o (stall_cnt),
`endif
    .stall_i     (stall),
    .pcsrc_i     (pcsrc),
    .target_i    (target),
    .imem_req_o  (req),
    .imem_addr_o (addr),
    .imem_ack_i  (ack),
    .imem_data_i (data),
    .if_valid_o  (valid),
    .if_instr_o  (instr),
    .if_pc_o     (ipc),
    .if_npc_o    (inpc)
  );

  // Reference model: "held" means IF/ID is being frozen on back-pressure.
  bit          m_started, m_held, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc, m_inpc;
  int unsigned m_fetches, m_stalls;

  function automatic bit m_req();
    return m_started && !m_held && !(m_valid && stall);
  endfunction

  task automatic model_step();
    bit r;
    r = m_req();
    if (!rst_n) begin
      m_started = 0; m_held = 0; m_valid = 0;
      m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_inpc = 0;
      m_fetches = 0; m_stalls = 0;
      return;
    end
    if (m_held) m_stalls++;
    if (!m_started) begin
      m_started = 1;
    end else if (pcsrc) begin
      m_pc = target; m_valid = 0; m_held = 0;
    end else if (m_held) begin
      if (!stall) begin m_held = 0; m_valid = 0; end
    end else if (r && ack) begin
      m_instr = data; m_ipc = m_pc; m_inpc = m_pc + 32'd1;
      m_pc = m_pc + 32'd1; m_valid = 1; m_held = stall; m_fetches++;
    end else if (m_valid && stall) begin
      m_held = 1;
    end else if (m_valid) begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("imem_req", {31'b0, req}, {31'b0, m_req()});
    chk("imem_addr", addr, m_pc);
    chk("if_valid", {31'b0, valid}, {31'b0, m_valid});
    chk("if_instr", instr, m_instr);
    chk("if_pc", ipc, m_ipc);
    chk("if_npc", inpc, m_inpc);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetches);
    chk("stall_cnt", stall_cnt, m_stalls);
`endif
  endtask

  task automatic drive(input bit r, input bit s, input bit a, input bit p,
                       input logic [31:0] t, input logic [31:0] d);
    rst_n = r; stall = s; ack = a; pcsrc = p; target = t; data = d;
  endtask

  // Called just after a falling edge; samples before the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          s, a, p;
    logic [31:0] t, d;
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_pc, e_npc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    //          s  a  p  target  data          req val addr      instr         pc  npc
    tbl[0]  = '{0, 1, 0, 32'h0,  32'hA000_0000, 0, 0, 32'h0,  32'h0,        0, 0};
    tbl[1]  = '{0, 1, 0, 32'h0,  32'hA000_0001, 1, 0, 32'h0,  32'h0,        0, 0};
    tbl[2]  = '{0, 1, 0, 32'h0,  32'hA000_0002, 1, 1, 32'h1,  32'hA000_0001, 0, 1};
    tbl[3]  = '{0, 1, 0, 32'h0,  32'hA000_0003, 1, 1, 32'h2,  32'hA000_0002, 1, 2};
    tbl[4]  = '{1, 1, 0, 32'h0,  32'hA000_0004, 0, 1, 32'h3,  32'hA000_0003, 2, 3};
    tbl[5]  = '{1, 1, 0, 32'h0,  32'hA000_0005, 0, 1, 32'h3,  32'hA000_0003, 2, 3};
    tbl[6]  = '{0, 1, 0, 32'h0,  32'hA000_0006, 0, 1, 32'h3,  32'hA000_0003, 2, 3};
    tbl[7]  = '{0, 0, 0, 32'h0,  32'hA000_0007, 1, 0, 32'h3,  32'hA000_0003, 2, 3};
    tbl[8]  = '{0, 0, 0, 32'h0,  32'hA000_0008, 1, 0, 32'h3,  32'hA000_0003, 2, 3};
    tbl[9]  = '{0, 1, 0, 32'h0,  32'hA000_0009, 1, 0, 32'h3,  32'hA000_0003, 2, 3};
    tbl[10] = '{0, 1, 1, 32'h40, 32'hA000_000A, 1, 1, 32'h4,  32'hA000_0009, 3, 4};
    tbl[11] = '{0, 0, 0, 32'h0,  32'hA000_000B, 1, 0, 32'h40, 32'hA000_0009, 3, 4};

    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].s, tbl[i].a, tbl[i].p, tbl[i].t, tbl[i].d);
      #1;
      chk($sformatf("tbl%0d.req", i), {31'b0, req}, {31'b0, tbl[i].e_req});
      chk($sformatf("tbl%0d.valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.addr", i), addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d.pc", i), ipc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.npc", i), inpc, tbl[i].e_npc);
      tick();
    end

    // Wrap: redirect to all-ones, fetch it, expect npc 0 and next address 0.
    drive(1, 0, 0, 1, 32'hFFFF_FFFF, 0);
    #1; chk_model(); tick();
    drive(1, 0, 1, 0, 0, 32'h1234_5678);
    #1; chk("wrap.addr", addr, 32'hFFFF_FFFF); chk_model(); tick();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("wrap.npc", inpc, 32'h0);
    chk("wrap.next_addr", addr, 32'h0);
    chk("wrap.instr", instr, 32'h1234_5678);
    tick();

    // Delayed ack: address held stable and request stays up for 4 cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      #1; chk("dly.req", {31'b0, req}, 32'h1); chk("dly.valid", {31'b0, valid}, 32'h0);
      chk_model(); tick();
    end
    drive(1, 0, 1, 0, 0, 32'hBEEF_0001);
    #1; chk_model(); tick();
    drive(1, 1, 0, 0, 0, 0);
    #1; chk("dly.valid_after", {31'b0, valid}, 32'h1); chk_model(); tick();

    // Hold in STALL, then reset while frozen.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      #1; chk("stl.req", {31'b0, req}, 32'h0); chk_model(); tick();
    end
    drive(0, 1, 1, 0, 0, 0);
    #1; tick();
    drive(1, 1, 1, 0, 0, 0);
    #1;
    chk("rst.req", {31'b0, req}, 32'h0);
    chk("rst.valid", {31'b0, valid}, 32'h0);
    chk("rst.addr", addr, 32'h0);
    chk("rst.pc", ipc, 32'h0);
    chk_model();
    tick();

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0), t, $urandom);
      #1;
      chk_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the program counter and the PC incrementer for the instruction-fetch stage of the pipelined MIPS datapath. Holds the PC register, issues word addresses to instruction memory over a req/ack handshake, and presents fetched instructions to the IF/ID register. Stalls on downstream back-pressure and redirects on branch/jump requests.

## Interface
- WIDTH, 32, PC/instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- stall  input  1  IF/ID not ready; output instruction must hold
- pcsrc  input  1  redirect request (branch/jump taken), single-cycle pulse
- target  input  WIDTH  redirect address, valid with pcsrc
- imem_req  output  1  fetch request
- imem_addr  output  WIDTH  fetch address (current PC)
- imem_ack  input  1  instruction returned this cycle; ignored while imem_req low
- imem_data  input  WIDTH  instruction word, valid with imem_ack
- if_valid  output  1  if_instr/if_pc/if_npc hold a live instruction
- if_instr  output  WIDTH  fetched instruction
- if_pc  output  WIDTH  address of if_instr
- if_npc  output  WIDTH  if_pc + 1 (incrementer output)
- fetch_cnt, stall_cnt  output  32  performance counters (FETCH_PERF_CNT_EN only)

## Operation
- States: IDLE, FETCH, STALL.
- Reset (rst_n low at edge): pc=RESET_PC, state=IDLE; imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_npc=0; counters 0.
- IDLE: unconditionally to FETCH next cycle.
- imem_addr = pc always. imem_req = (state==FETCH) && !(if_valid && stall).
- FETCH, accepted ack (imem_req && imem_ack && !pcsrc): if_instr<=imem_data, if_pc<=pc, if_npc<=pc+1, if_valid<=1, pc<=pc+1. If stall high, go STALL; else stay FETCH.
- FETCH, no ack: addr held stable; if_valid cleared when consumed (if_valid && !stall).
- FETCH with if_valid && stall: go STALL, imem_req low.
- STALL: outputs frozen, imem_req=0; stall low → FETCH, with if_valid cleared that edge (consumed).
- pcsrc (any state except IDLE): highest priority over ack and stall. pc<=target, if_valid<=0, state<=FETCH; an ack in the same cycle is discarded and pc not incremented.
- Arithmetic: pc+1 modulo 2^WIDTH; 0xFFFFFFFF wraps to 0, no flag.
- Reset mid-handshake: outstanding request abandoned; memory must tolerate req dropping.

## Timing
- First imem_req: second rising edge after rst_n sampled high (one IDLE cycle).
- Ack in cycle N → if_valid/if_instr in cycle N+1; next address on imem_addr in N+1.
- Zero-wait memory (ack tied high), no stall: one instruction per cycle.
- pcsrc in cycle N → imem_addr=target in N+1, if_valid=0 in N+1.
- imem_req is combinational from state, if_valid, stall; all other outputs registered.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_cnt increments on each accepted ack; stall_cnt increments each cycle in STALL; both saturate at 0xFFFFFFFF, reset to 0.
- Undefined: ports and counter logic absent; behaviour otherwise identical.

## Structure
- Shared header fetch_defs.vh: state encodings (IDLE=2'd0, FETCH=2'd1, STALL=2'd2), default RESET_PC.
- One sub-module: the existing incrementer (pcin=pc, pcout → pc+1 path and if_npc source).

## Test plan
- Reset release, RESET_PC=0, ack tied 1, stall 0 → imem_addr 0,1,2,3 on consecutive cycles; if_pc 0,1,2 one cycle later; if_npc=if_pc+1.
- Ack delayed 3 cycles at pc=5 → imem_req high, imem_addr=5 stable for 4 cycles, if_valid low until cycle after ack.
- stall high 4 cycles while if_pc=7 valid → if_instr/if_pc frozen, imem_req 0, state STALL; on release next addr 8; stall_cnt=4 with macro.
- pcsrc with target=0x40 coincident with ack → ack data dropped, if_valid 0 next cycle, imem_addr=0x40, fetch_cnt unchanged.
- Fetch at pc=0xFFFFFFFF → if_npc=0, next imem_addr=0.
- rst_n low during STALL → next edge: all outputs 0, imem_req 0, pc=RESET_PC, counters 0.
